// File: rtl/shiftout_pkg.sv
// Shared types and elaboration helpers for the multi-lane shift-out stage.
package shiftout_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
  endfunction

  function automatic int calc_beats(input int data_width, input int lanes);
    return data_width / lanes;
  endfunction

endpackage

// File: rtl/shiftout_holdbuf.sv
// One-entry holding buffer for a product word and its bit order, with full flag.
module shiftout_holdbuf
  import shiftout_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_msb,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_msb,
  output logic                  full
);

  // push only happens mid-word and pop only on a last beat, so they never coincide
  always_ff @(posedge Clk) begin
    if (reset) begin
      full     <= 1'b0;
      dout     <= '0;
      dout_msb <= 1'b0;
    end else if (push) begin
      full     <= 1'b1;
      dout     <= din;
      dout_msb <= din_msb;
    end else if (pop) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/shiftout_lanes.sv
// Multi-lane parallel-to-serial shifter with one-word holding buffer.
// Define SHIFTOUT_PARITY_EN to append an even-parity beat after each word.
module shiftout_lanes
  import shiftout_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Z_parallel,
  input  logic                  Msb_first,
  input  logic                  Sx,
  output logic                  Ready,
  output logic [LANES-1:0]      Z_out,
  output logic                  Z_valid,
  output logic                  Fx,
  output logic                  Busy
);

  localparam int BEATS = calc_beats(DATA_WIDTH, LANES);
  localparam int CNT_W = $clog2(BEATS + 1);
`ifdef SHIFTOUT_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
`endif

  if (DATA_WIDTH % LANES != 0) begin : g_bad_width
    $error("shiftout_lanes: DATA_WIDTH must be a multiple of LANES");
  end
  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("shiftout_lanes: LANES must be 1, 2, 4 or 8");
  end

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] sr, sr_next;
  logic                  msb, msb_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [DATA_WIDTH-1:0] hold_word;
  logic                  hold_msb, hold_full;
  logic                  push, pop, load, accept, last_beat;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  load_msb;
  logic [LANES-1:0]      z_beat;
`ifdef SHIFTOUT_PARITY_EN
  logic                  par, par_next;
`endif

  assign Ready     = !hold_full;
  assign accept    = Sx && Ready;
  assign Busy      = (state == ST_SHIFT);
  assign Z_valid   = Busy;
  assign last_beat = Busy && (cnt == LAST_CNT);
  assign Fx        = last_beat;

  shiftout_holdbuf #(.DATA_WIDTH(DATA_WIDTH)) u_holdbuf (
    .Clk      (Clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (Z_parallel),
    .din_msb  (Msb_first),
    .dout     (hold_word),
    .dout_msb (hold_msb),
    .full     (hold_full)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sr    <= '0;
      msb   <= 1'b0;
      cnt   <= '0;
`ifdef SHIFTOUT_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      sr    <= sr_next;
      msb   <= msb_next;
      cnt   <= cnt_next;
`ifdef SHIFTOUT_PARITY_EN
      par   <= par_next;
`endif
    end
  end

  // On the last beat the held word wins over a fresh one, keeping words in order
  always_comb begin
    state_next = state;
    sr_next    = sr;
    msb_next   = msb;
    cnt_next   = cnt;
    push       = 1'b0;
    pop        = 1'b0;
    load       = 1'b0;
    load_word  = Z_parallel;
    load_msb   = Msb_first;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_next  = msb ? (sr << LANES) : (sr >> LANES);
        cnt_next = cnt + CNT_W'(1);
        if (last_beat) begin
          if (hold_full) begin
            load      = 1'b1;
            pop       = 1'b1;
            load_word = hold_word;
            load_msb  = hold_msb;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (accept) begin
          push = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (load) begin
      sr_next  = load_word;
      msb_next = load_msb;
      cnt_next = '0;
    end
`ifdef SHIFTOUT_PARITY_EN
    par_next = load ? ^load_word : par;
`endif
  end

  always_comb begin
    z_beat = msb ? sr[DATA_WIDTH-1 -: LANES] : sr[LANES-1:0];
`ifdef SHIFTOUT_PARITY_EN
    if (cnt == CNT_W'(BEATS)) z_beat = LANES'(par);
`endif
  end

  assign Z_out = Z_valid ? z_beat : '0;

endmodule

// File: tb/tb_shiftout_lanes.sv
// Directed self-checking bench: one LANES=1 and one LANES=4 instance of shiftout_lanes.
module tb_shiftout_lanes;

`ifdef SHIFTOUT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  logic [15:0] zp1, zp4;
  logic        msb1, sx1, rdy1, zv1, fx1, busy1;
  logic        msb4, sx4, rdy4, zv4, fx4, busy4;
  logic [0:0]  zo1;
  logic [3:0]  zo4;

  int n_cmp = 0;
  int n_bad = 0;

  shiftout_lanes #(.DATA_WIDTH(16), .LANES(1)) u1 (
    .Clk(Clk), .reset(reset), .Z_parallel(zp1), .Msb_first(msb1), .Sx(sx1),
    .Ready(rdy1), .Z_out(zo1), .Z_valid(zv1), .Fx(fx1), .Busy(busy1)
  );

  shiftout_lanes #(.DATA_WIDTH(16), .LANES(4)) u4 (
    .Clk(Clk), .reset(reset), .Z_parallel(zp4), .Msb_first(msb4), .Sx(sx4),
    .Ready(rdy4), .Z_out(zo4), .Z_valid(zv4), .Fx(fx4), .Busy(busy4)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sx1 = 1'b0; sx4 = 1'b0;
    zp1 = '0;   zp4 = '0;
    msb1 = 1'b0; msb4 = 1'b0;
    step();
    step();
    n_cmp++;
    if ({rdy1, zv1, fx1, busy1, zo1} !== 5'b10000) begin
      n_bad++;
      $display("[TB] FAIL reset_l1: got rdy/zv/fx/busy/z=%b expected 10000", {rdy1, zv1, fx1, busy1, zo1});
    end
    n_cmp++;
    if ({rdy4, zv4, fx4, busy4, zo4} !== 8'b1000_0000) begin
      n_bad++;
      $display("[TB] FAIL reset_l4: got rdy/zv/fx/busy/z=%b expected 10000000", {rdy4, zv4, fx4, busy4, zo4});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lsb_lanes1();
    int exp_bits[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int valid_cycles = 0;
    logic e_zv, e_z, e_fx;
    zp1 = 16'hA5C3; msb1 = 1'b0; sx1 = 1'b1;
    step();
    sx1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      e_zv = (i < 16 + PAR);
      e_z  = (i < 16) ? exp_bits[i][0] : 1'b0;
      e_fx = (i == 15 + PAR);
      valid_cycles += int'(zv1);
      n_cmp++;
      if ({zv1, zo1, fx1} !== {e_zv, e_z, e_fx}) begin
        n_bad++;
        $display("[TB] FAIL lsb_l1 beat %0d: got zv/z/fx=%b expected %b", i, {zv1, zo1, fx1}, {e_zv, e_z, e_fx});
      end
      step();
    end
    n_cmp++;
    if (valid_cycles != 16 + PAR) begin
      n_bad++;
      $display("[TB] FAIL lsb_l1_valid_count: got %0d expected %0d", valid_cycles, 16 + PAR);
    end
  endtask

  task automatic test_msb_lanes4();
    logic       e_zv, e_fx;
    logic [3:0] e_z;
    zp4 = 16'h1234; msb4 = 1'b1; sx4 = 1'b1;
    step();
    sx4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      e_zv = (i < 4 + PAR);
      e_z  = (i < 4) ? 4'(i + 1) : ((i == 4 && PAR == 1) ? 4'h1 : 4'h0);
      e_fx = (i == 3 + PAR);
      n_cmp++;
      if ({zv4, zo4, fx4} !== {e_zv, e_z, e_fx}) begin
        n_bad++;
        $display("[TB] FAIL msb_l4 beat %0d: got zv/z/fx=%b expected %b", i, {zv4, zo4, fx4}, {e_zv, e_z, e_fx});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[3]  = '{16'hABCD, 16'h1234, 16'h0F5A};
    logic        orders[3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0]  hb[3][4]  = '{'{4'hD, 4'hC, 4'hB, 4'hA},
                               '{4'h1, 4'h2, 4'h3, 4'h4},
                               '{4'hA, 4'h5, 4'hF, 4'h0}};
    logic        pars[3]   = '{1'b0, 1'b1, 1'b0};
    logic [4:0]  exp_q[$];
    int          idx = 0;
    int          w = 0;
    logic        started = 1'b0;
    logic        ready_low = 1'b0;
    logic        acc;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 4; b++) exp_q.push_back({(b == 3 && PAR == 0), hb[k][b]});
      if (PAR == 1) exp_q.push_back({1'b1, 3'b000, pars[k]});
    end
    zp4 = words[0]; msb4 = orders[0]; sx4 = 1'b1;
    for (int cyc = 0; cyc < 40 && idx < exp_q.size(); cyc++) begin
      acc = sx4 && rdy4;
      step();
      if (acc) begin
        w++;
        if (w < 3) begin
          zp4 = words[w]; msb4 = orders[w];
        end else begin
          sx4 = 1'b0;
        end
      end
      if (!rdy4) ready_low = 1'b1;
      if (zv4) begin
        started = 1'b1;
        n_cmp++;
        if ({fx4, zo4} !== exp_q[idx]) begin
          n_bad++;
          $display("[TB] FAIL b2b beat %0d: got fx/z=%b expected %b", idx, {fx4, zo4}, exp_q[idx]);
        end
        idx++;
      end else if (started) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL b2b_gap at beat %0d: got Z_valid=0 expected 1", idx);
      end
    end
    n_cmp++;
    if (idx != exp_q.size()) begin
      n_bad++;
      $display("[TB] FAIL b2b_beat_count: got %0d expected %0d", idx, exp_q.size());
    end
    n_cmp++;
    if (ready_low !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL b2b_ready_low: got %b expected 1", ready_low);
    end
    step();
    n_cmp++;
    if ({zv4, fx4, rdy4, busy4} !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL b2b_drain: got zv/fx/rdy/busy=%b expected 0010", {zv4, fx4, rdy4, busy4});
    end
  endtask

  task automatic test_reset_mid_word();
    logic e_zv, e_z, e_fx;
    zp1 = 16'hFFFF; msb1 = 1'b0; sx1 = 1'b1;
    step();
    zp1 = 16'h1111;
    step();
    sx1 = 1'b0;
    n_cmp++;
    if (rdy1 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL mid_ready_full: got %b expected 0", rdy1);
    end
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if ({zv1, zo1, fx1} !== 3'b110) begin
      n_bad++;
      $display("[TB] FAIL mid_beat5: got zv/z/fx=%b expected 110", {zv1, zo1, fx1});
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if ({zv1, fx1, rdy1, busy1, zo1} !== 5'b00100) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: got zv/fx/rdy/busy/z=%b expected 00100", {zv1, fx1, rdy1, busy1, zo1});
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({zv1, busy1, rdy1} !== 3'b001) begin
      n_bad++;
      $display("[TB] FAIL mid_after_reset: got zv/busy/rdy=%b expected 001", {zv1, busy1, rdy1});
    end
    zp1 = 16'h00F0; msb1 = 1'b0; sx1 = 1'b1;
    step();
    sx1 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      e_zv = (i < 16 + PAR);
      e_z  = (i >= 4 && i <= 7);
      e_fx = (i == 15 + PAR);
      n_cmp++;
      if ({zv1, zo1, fx1} !== {e_zv, e_z, e_fx}) begin
        n_bad++;
        $display("[TB] FAIL mid_reload beat %0d: got zv/z/fx=%b expected %b", i, {zv1, zo1, fx1}, {e_zv, e_z, e_fx});
      end
      step();
    end
  endtask

  task automatic test_last_beat_accept();
    int         waited = 0;
    logic       e_zv, e_fx;
    logic [3:0] e_z;
    logic [3:0] second[4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    zp4 = 16'h8421; msb4 = 1'b0; sx4 = 1'b1;
    step();
    sx4 = 1'b0;
    while (!fx4 && waited < 10) begin
      step();
      waited++;
    end
    n_cmp++;
    if (waited != 3 + PAR) begin
      n_bad++;
      $display("[TB] FAIL lba_fx_position: got %0d cycles expected %0d", waited, 3 + PAR);
    end
    n_cmp++;
    if ({fx4, zo4} !== {1'b1, (PAR == 1) ? 4'h0 : 4'h8}) begin
      n_bad++;
      $display("[TB] FAIL lba_last_beat: got fx/z=%b expected %b", {fx4, zo4}, {1'b1, (PAR == 1) ? 4'h0 : 4'h8});
    end
    zp4 = 16'h5678; msb4 = 1'b1; sx4 = 1'b1;
    step();
    sx4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      e_zv = (i < 4 + PAR);
      e_z  = (i < 4) ? second[i] : 4'h0;
      e_fx = (i == 3 + PAR);
      n_cmp++;
      if ({zv4, zo4, fx4} !== {e_zv, e_z, e_fx}) begin
        n_bad++;
        $display("[TB] FAIL lba_second beat %0d: got zv/z/fx=%b expected %b", i, {zv4, zo4, fx4}, {e_zv, e_z, e_fx});
      end
      step();
    end
  endtask

`ifdef SHIFTOUT_PARITY_EN
  task automatic test_parity();
    logic [15:0] pw[2]   = '{16'h0001, 16'h0003};
    logic        ppar[2] = '{1'b1, 1'b0};
    logic        e_zv, e_z, e_fx;
    for (int k = 0; k < 2; k++) begin
      zp1 = pw[k]; msb1 = 1'b0; sx1 = 1'b1;
      step();
      sx1 = 1'b0;
      for (int i = 0; i < 18; i++) begin
        e_zv = (i < 17);
        e_z  = (i < 16) ? pw[k][i] : ((i == 16) ? ppar[k] : 1'b0);
        e_fx = (i == 16);
        n_cmp++;
        if ({zv1, zo1, fx1} !== {e_zv, e_z, e_fx}) begin
          n_bad++;
          $display("[TB] FAIL parity w%0d beat %0d: got zv/z/fx=%b expected %b", k, i, {zv1, zo1, fx1}, {e_zv, e_z, e_fx});
        end
        step();
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_lanes1();
    test_msb_lanes4();
    test_back_to_back();
    test_reset_mid_word();
    test_last_beat_accept();
`ifdef SHIFTOUT_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
